// File: rtl/freq_divider_prog.sv
`default_nettype none
// ============================================================================
// Module   : freq_divider_prog
// Brief    : Programmable integer clock divider (ratio 2..2^N-1, 0 = stop)
//            with glitch-free boundary-aligned ratio updates and req/ack.
// Revision : 1.0
// ============================================================================
module freq_divider_prog #(
    parameter int NUM_DIVISOR_BITS = 6
) (
    input  logic                        in,
    input  logic                        reset,
    input  logic [NUM_DIVISOR_BITS-1:0] divisor,
    input  logic                        update_req,
    output logic                        update_ack,
    input  logic                        enable,
    output logic                        out,
    output logic                        period_pulse,
    output logic                        running
);

    localparam logic [NUM_DIVISOR_BITS-1:0] ZERO = '0;
    localparam logic [NUM_DIVISOR_BITS-1:0] ONE  = NUM_DIVISOR_BITS'(1);
    localparam logic [NUM_DIVISOR_BITS-1:0] TWO  = NUM_DIVISOR_BITS'(2);

    logic [NUM_DIVISOR_BITS-1:0] cnt;
    logic [NUM_DIVISOR_BITS-1:0] d_act;
    logic [NUM_DIVISOR_BITS-1:0] d_pend;
    logic                        pend_valid;

    logic [NUM_DIVISOR_BITS-1:0] req_norm;
    logic [NUM_DIVISOR_BITS-1:0] half;
    logic [NUM_DIVISOR_BITS-1:0] cnt_next;
    logic [NUM_DIVISOR_BITS-1:0] new_d;
    logic                        boundary;
    logic                        apply_now;
    logic                        do_apply;

    always_comb begin
        req_norm  = (divisor == ONE) ? TWO : divisor;
        // ceil(d_act/2) without the carry out of d_act+1 at the top ratio
        half      = (d_act >> 1) + {{(NUM_DIVISOR_BITS-1){1'b0}}, d_act[0]};
        boundary  = (d_act != ZERO) && enable && (cnt == d_act - ONE);
        cnt_next  = boundary ? ZERO : cnt + ONE;
        apply_now = (d_act == ZERO) || boundary;
        new_d     = update_req ? req_norm : d_pend;
        do_apply  = apply_now && (update_req || pend_valid);
    end

    always_ff @(posedge in or negedge reset) begin
        if (!reset) begin
            cnt          <= ZERO;
            out          <= 1'b0;
            period_pulse <= 1'b0;
            update_ack   <= 1'b0;
            d_act        <= ZERO;
            d_pend       <= ZERO;
            pend_valid   <= 1'b0;
            running      <= 1'b0;
        end else begin
            update_ack <= 1'b0;
            if (do_apply) begin
                // a request arriving on an apply edge takes effect immediately
                d_act        <= new_d;
                cnt          <= ZERO;
                out          <= (new_d != ZERO);
                period_pulse <= (new_d != ZERO);
                running      <= (new_d != ZERO);
                update_ack   <= 1'b1;
                pend_valid   <= 1'b0;
            end else begin
                if (update_req) begin
                    d_pend     <= req_norm;
                    pend_valid <= 1'b1;
                end
                if ((d_act != ZERO) && enable) begin
                    cnt          <= cnt_next;
                    out          <= (cnt_next < half);
                    period_pulse <= (cnt_next == ZERO);
                end else begin
                    period_pulse <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_freq_divider_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_divider_prog
// Brief    : Directed self-checking bench for freq_divider_prog.
// Revision : 1.0
// ============================================================================
module tb_freq_divider_prog;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] div;
    logic       req;
    logic       en;
    logic       ack;
    logic       dout;
    logic       pp;
    logic       run;

    int passed = 0;
    int total  = 0;

    freq_divider_prog #(.NUM_DIVISOR_BITS(6)) dut (
        .in          (clk),
        .reset       (rst_n),
        .divisor     (div),
        .update_req  (req),
        .update_ack  (ack),
        .enable      (en),
        .out         (dout),
        .period_pulse(pp),
        .running     (run)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Records out/period_pulse for n cycles (first cycle in MSB) and counts acks.
    task automatic capture(input int n, output logic [31:0] o, output logic [31:0] p,
                           output int acks);
        o = '0;
        p = '0;
        acks = 0;
        for (int i = 0; i < n; i++) begin
            o = {o[30:0], dout};
            p = {p[30:0], pp};
            if (ack) acks++;
            step();
        end
    endtask

    task automatic req_pulse(input logic [5:0] d);
        div = d;
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] o, p;
        int a;
        rst_n = 1'b0; div = '0; req = 1'b0; en = 1'b1;
        repeat (3) step();
        total++; if (dout !== 1'b0) $display("FAIL reset_out got %b want 0", dout); else passed++;
        total++; if (pp !== 1'b0) $display("FAIL reset_pp got %b want 0", pp); else passed++;
        total++; if (ack !== 1'b0) $display("FAIL reset_ack got %b want 0", ack); else passed++;
        total++; if (run !== 1'b0) $display("FAIL reset_run got %b want 0", run); else passed++;
        rst_n = 1'b1;
        capture(4, o, p, a);
        total++; if (o !== 32'b0) $display("FAIL idle_out got %b want 0", o); else passed++;
        total++; if (a !== 0) $display("FAIL idle_ack got %0d want 0", a); else passed++;
    endtask

    task automatic test_startup();
        logic [31:0] o, p;
        int a;
        req_pulse(6'd4);
        total++; if (ack !== 1'b1) $display("FAIL start_ack got %b want 1", ack); else passed++;
        total++; if (run !== 1'b1) $display("FAIL start_run got %b want 1", run); else passed++;
        capture(12, o, p, a);
        total++; if (o !== 32'b110011001100) $display("FAIL start_out got %b want 110011001100", o); else passed++;
        total++; if (p !== 32'b100010001000) $display("FAIL start_pp got %b want 100010001000", p); else passed++;
        total++; if (a !== 1) $display("FAIL start_acks got %0d want 1", a); else passed++;
    endtask

    task automatic test_odd();
        logic [31:0] o, p;
        int a;
        req_pulse(6'd5);
        capture(18, o, p, a);
        total++; if (o !== 32'b100111001110011100) $display("FAIL odd5_out got %b want 100111001110011100", o); else passed++;
        total++; if (p !== 32'b000100001000010000) $display("FAIL odd5_pp got %b want 000100001000010000", p); else passed++;
        total++; if (a !== 1) $display("FAIL odd5_acks got %0d want 1", a); else passed++;
        req_pulse(6'd1);
        capture(12, o, p, a);
        total++; if (o !== 32'b110010101010) $display("FAIL div1_out got %b want 110010101010", o); else passed++;
        total++; if (p !== 32'b000010101010) $display("FAIL div1_pp got %b want 000010101010", p); else passed++;
    endtask

    task automatic test_runtime_change();
        logic [31:0] o, p;
        int a;
        req_pulse(6'd4);
        capture(5, o, p, a);
        total++; if (o !== 32'b01100) $display("FAIL to4_out got %b want 01100", o); else passed++;
        total++; if (a !== 1) $display("FAIL to4_acks got %0d want 1", a); else passed++;
        step();
        req_pulse(6'd6);
        capture(14, o, p, a);
        total++; if (o !== 32'b00111000111000) $display("FAIL to6_out got %b want 00111000111000", o); else passed++;
        total++; if (p !== 32'b00100000100000) $display("FAIL to6_pp got %b want 00100000100000", p); else passed++;
        total++; if (a !== 1) $display("FAIL to6_acks got %0d want 1", a); else passed++;
    endtask

    task automatic test_latest_wins();
        logic [31:0] o, p;
        int a;
        req_pulse(6'd7);
        step();
        req_pulse(6'd3);
        capture(12, o, p, a);
        total++; if (o !== 32'b000110110110) $display("FAIL latest_out got %b want 000110110110", o); else passed++;
        total++; if (p !== 32'b000100100100) $display("FAIL latest_pp got %b want 000100100100", p); else passed++;
        total++; if (a !== 1) $display("FAIL latest_acks got %0d want 1", a); else passed++;
    endtask

    task automatic test_boundary_bypass();
        logic [31:0] o, p;
        int a;
        step();
        step();
        req_pulse(6'd4);
        total++; if (ack !== 1'b1) $display("FAIL bypass_ack got %b want 1", ack); else passed++;
        capture(8, o, p, a);
        total++; if (o !== 32'b11001100) $display("FAIL bypass_out got %b want 11001100", o); else passed++;
        total++; if (p !== 32'b10001000) $display("FAIL bypass_pp got %b want 10001000", p); else passed++;
    endtask

    task automatic test_enable_hold();
        logic [31:0] o, p;
        int a;
        step();
        en = 1'b0;
        capture(5, o, p, a);
        total++; if (o !== 32'b11111) $display("FAIL hold_out got %b want 11111", o); else passed++;
        total++; if (p !== 32'b00000) $display("FAIL hold_pp got %b want 00000", p); else passed++;
        en = 1'b1;
        capture(7, o, p, a);
        total++; if (o !== 32'b1001100) $display("FAIL resume_out got %b want 1001100", o); else passed++;
        total++; if (p !== 32'b0001000) $display("FAIL resume_pp got %b want 0001000", p); else passed++;
    endtask

    task automatic test_stop();
        logic [31:0] o, p;
        int a;
        req_pulse(6'd0);
        total++; if (run !== 1'b1) $display("FAIL stop_run_early got %b want 1", run); else passed++;
        capture(7, o, p, a);
        total++; if (o !== 32'b1000000) $display("FAIL stop_out got %b want 1000000", o); else passed++;
        total++; if (p !== 32'b0) $display("FAIL stop_pp got %b want 0", p); else passed++;
        total++; if (a !== 1) $display("FAIL stop_acks got %0d want 1", a); else passed++;
        total++; if (run !== 1'b0) $display("FAIL stop_run got %b want 0", run); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] o, p;
        int a;
        req_pulse(6'd4);
        req_pulse(6'd6);
        total++; if (dout !== 1'b1) $display("FAIL premid_out got %b want 1", dout); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (dout !== 1'b0) $display("FAIL async_out got %b want 0", dout); else passed++;
        total++; if (run !== 1'b0) $display("FAIL async_run got %b want 0", run); else passed++;
        step();
        step();
        rst_n = 1'b1;
        capture(8, o, p, a);
        total++; if (o !== 32'b0) $display("FAIL postrst_out got %b want 0", o); else passed++;
        total++; if (a !== 0) $display("FAIL postrst_acks got %0d want 0", a); else passed++;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_odd();
        test_runtime_change();
        test_latest_wins();
        test_boundary_bypass();
        test_enable_hold();
        test_stop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
